wb_regfile_slave: RTL

- Parametrised Wishbone classic slave register file for the 10G MAC host interface. Next generation of the fixed 8-bit address / 32-bit data host port.
- Adds configurable widths, a configurable number of config registers, byte-lane writes, programmable ack wait states, error termination for unmapped addresses, and a maskable edge-latched interrupt controller driving wb_int_o.
- Sits between the host Wishbone bus and MAC core control and status signals.

---
 rtl/wb_regfile_slave.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_regfile_slave.sv
// Wishbone classic register file slave: config registers, W1C interrupt pending,
// interrupt mask and read-only status, with programmable ack wait states.
module wb_regfile_slave #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CFG_REGS = 4,
   parameter int NUM_IRQ      = 8,
   parameter int STATUS_WIDTH = 16,
   parameter int ACK_WAIT     = 1
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_i,
   input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
   input  logic [DATA_WIDTH-1:0]            wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0]          wb_sel_i,
   input  logic                             wb_we_i,
   input  logic                             wb_cyc_i,
   input  logic                             wb_stb_i,
   output logic [DATA_WIDTH-1:0]            wb_dat_o,
   output logic                             wb_ack_o,
   output logic                             wb_err_o,
   output logic                             wb_int_o,
   input  logic [NUM_IRQ-1:0]               irq_i,
   input  logic [STATUS_WIDTH-1:0]          status_i,
   output logic [NUM_CFG_REGS*DATA_WIDTH-1:0] cfg_o
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(SEL_W);
   localparam logic [ADDR_WIDTH-1:0] IDX_PEND = ADDR_WIDTH'(NUM_CFG_REGS);
   localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(NUM_CFG_REGS + 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_STAT = ADDR_WIDTH'(NUM_CFG_REGS + 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SEL_W-1:0] sel);
      logic [DATA_WIDTH-1:0] m;
      for (int j = 0; j < SEL_W; j++) m[j*8 +: 8] = {8{sel[j]}};
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [SEL_W-1:0]      sel);
      return (old_v & ~lane_mask(sel)) | (new_v & lane_mask(sel));
   endfunction

   state_t                 state;
   logic [3:0]             cnt;
   logic [ADDR_WIDTH-1:0]  adr_q;
   logic [DATA_WIDTH-1:0]  dat_q;
   logic [SEL_W-1:0]       sel_q;
   logic                   we_q;
   logic [DATA_WIDTH-1:0]  cfg [NUM_CFG_REGS];
   logic [NUM_IRQ-1:0]     pend, mask, irq_prev, w1c;

   logic [ADDR_WIDTH-1:0]  acc_adr, acc_idx;
   logic [DATA_WIDTH-1:0]  acc_dat, rdata;
   logic [SEL_W-1:0]       acc_sel;
   logic                   acc_we, go_resp, hit;

   // With no wait states the response edge is the capture edge, so live bus inputs are used.
   always_comb begin
      acc_adr = (state == IDLE) ? wb_adr_i : adr_q;
      acc_dat = (state == IDLE) ? wb_dat_i : dat_q;
      acc_sel = (state == IDLE) ? wb_sel_i : sel_q;
      acc_we  = (state == IDLE) ? wb_we_i  : we_q;
      acc_idx = acc_adr >> SHIFT;
      hit     = (acc_idx <= IDX_STAT);
      go_resp = 1'b0;
      if (state == IDLE && wb_cyc_i && wb_stb_i && ACK_WAIT == 0) go_resp = 1'b1;
      if (state == WAIT && wb_cyc_i && cnt == 4'd1) go_resp = 1'b1;
      w1c = '0;
      if (go_resp && acc_we && acc_idx == IDX_PEND)
         w1c = NUM_IRQ'(acc_dat & lane_mask(acc_sel));
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CFG_REGS; i++)
         if (acc_idx == ADDR_WIDTH'(i)) rdata = cfg[i];
      if (acc_idx == IDX_PEND) rdata = DATA_WIDTH'(pend);
      if (acc_idx == IDX_MASK) rdata = DATA_WIDTH'(mask);
      if (acc_idx == IDX_STAT) rdata = DATA_WIDTH'(status_i);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         mask     <= '0;
         for (int i = 0; i < NUM_CFG_REGS; i++) cfg[i] <= '0;
      end else begin
         case (state)
            IDLE: if (wb_cyc_i && wb_stb_i) begin
               adr_q <= wb_adr_i;
               dat_q <= wb_dat_i;
               sel_q <= wb_sel_i;
               we_q  <= wb_we_i;
               if (ACK_WAIT == 0) state <= RESP;
               else begin
                  state <= WAIT;
                  cnt   <= 4'(ACK_WAIT);
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (!wb_cyc_i) state <= IDLE;
               else if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               state    <= IDLE;
               wb_ack_o <= 1'b0;
               wb_err_o <= 1'b0;
               wb_dat_o <= '0;
            end
            default: state <= IDLE;
         endcase
         if (go_resp) begin
            if (hit) begin
               wb_ack_o <= 1'b1;
               wb_dat_o <= acc_we ? '0 : rdata;
               if (acc_we) begin
                  for (int i = 0; i < NUM_CFG_REGS; i++)
                     if (acc_idx == ADDR_WIDTH'(i)) cfg[i] <= lane_merge(cfg[i], acc_dat, acc_sel);
                  if (acc_idx == IDX_MASK)
                     mask <= NUM_IRQ'(lane_merge(DATA_WIDTH'(mask), acc_dat, acc_sel));
               end
            end else begin
               wb_err_o <= 1'b1;
               wb_dat_o <= '0;
            end
         end
      end
   end

   // A new rising edge outranks a simultaneous W1C clear of the same bit.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         irq_prev <= '0;
         pend     <= '0;
         wb_int_o <= 1'b0;
      end else begin
         irq_prev <= irq_i;
         pend     <= (pend & ~w1c) | (irq_i & ~irq_prev);
         wb_int_o <= |(pend & mask);
      end
   end

   for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg
      assign cfg_o[g*DATA_WIDTH +: DATA_WIDTH] = cfg[g];
   end

endmodule
